// File: rtl/aes_inv_cipher_iter_if.sv
// Handshake, key-table and result signals of the iterative AES inverse cipher.
// The slave modport is the cipher's view; master is the environment's view.
interface aes_inv_cipher_iter_if #(
  parameter int RK_IDX_W = 4
);
  logic                in_valid;
  logic                in_ready;
  logic [127:0]        data_in;
  logic [RK_IDX_W-1:0] rk_idx;
  logic [127:0]        rk_data;
  logic                out_valid;
  logic                out_ready;
  logic [127:0]        data_out;
  logic                busy;

  modport slave (
    input  in_valid, data_in, rk_data, out_ready,
    output in_ready, rk_idx, out_valid, data_out, busy
  );

  modport master (
    output in_valid, data_in, rk_data, out_ready,
    input  in_ready, rk_idx, out_valid, data_out, busy
  );
endinterface

// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES inverse cipher: one decryption round per clock, round keys
// requested one per cycle from an external table through a registered rk_idx.
module aes_inv_cipher_iter #(
  parameter int NUM_ROUNDS = 10,
  parameter int RK_IDX_W   = 4
) (
  input logic                  clk,
  input logic                  rst,
  aes_inv_cipher_iter_if.slave bus
);

  if (NUM_ROUNDS != 10 && NUM_ROUNDS != 12 && NUM_ROUNDS != 14) begin : g_bad_rounds
    $error("aes_inv_cipher_iter: NUM_ROUNDS must be 10, 12 or 14");
  end

  typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} fsm_t;

  localparam logic [RK_IDX_W-1:0] RK_LAST = RK_IDX_W'(NUM_ROUNDS);
  localparam logic [RK_IDX_W-1:0] RK_ONE  = RK_IDX_W'(1);

  // Inverse S-box, entry 0 in the top byte.
  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [3:0] m);
    logic [7:0] x2, x4, x8;
    x2 = xt(a);
    x4 = xt(x2);
    x8 = xt(x4);
    return (m[0] ? a : 8'h00) ^ (m[1] ? x2 : 8'h00) ^ (m[2] ? x4 : 8'h00) ^ (m[3] ? x8 : 8'h00);
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    for (int i = 0; i < 16; i++)
      o[127-8*i -: 8] = INV_SBOX[{~s[127-8*i -: 8], 3'b111} -: 8];
    return o;
  endfunction

  // Byte (row r, column c) lives at index r + 4c; row r rotates right by r.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+4-r)%4)) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a [4];
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) a[r] = s[127-8*(r+4*c) -: 8];
      for (int r = 0; r < 4; r++)
        o[127-8*(r+4*c) -: 8] = gf_mul(a[r], 4'he) ^ gf_mul(a[(r+1)%4], 4'hb) ^
                                gf_mul(a[(r+2)%4], 4'hd) ^ gf_mul(a[(r+3)%4], 4'h9);
    end
    return o;
  endfunction

  fsm_t                fsm, fsm_next;
  logic [RK_IDX_W-1:0] rnd, rnd_next;
  logic [RK_IDX_W-1:0] rk_idx_q, rk_idx_next;
  logic [127:0]        state_reg, state_next;
  logic [127:0]        dout, dout_next;

  always_comb begin
    fsm_next   = fsm;
    rnd_next   = rnd;
    state_next = state_reg;
    dout_next  = dout;
    unique case (fsm)
      IDLE: begin
        if (bus.in_valid) begin
          state_next = bus.data_in ^ bus.rk_data;
          rnd_next   = RK_LAST - RK_ONE;
          fsm_next   = ROUND;
        end
      end
      ROUND: begin
        state_next = inv_mix_columns(inv_sub_bytes(inv_shift_rows(state_reg)) ^ bus.rk_data);
        if (rnd == RK_ONE) begin
          rnd_next = '0;
          fsm_next = FINAL;
        end else begin
          rnd_next = rnd - RK_ONE;
        end
      end
      FINAL: begin
        dout_next = inv_sub_bytes(inv_shift_rows(state_reg)) ^ bus.rk_data;
        fsm_next  = DONE;
      end
      DONE: begin
        if (bus.out_ready) fsm_next = IDLE;
      end
      default: fsm_next = IDLE;
    endcase
  end

  // rk_idx is registered from the next state so the key table sees a glitch-free index.
  always_comb begin
    rk_idx_next = RK_LAST;
    if (fsm_next == ROUND)      rk_idx_next = rnd_next;
    else if (fsm_next == FINAL) rk_idx_next = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm       <= IDLE;
      rnd       <= '0;
      rk_idx_q  <= RK_LAST;
      state_reg <= '0;
      dout      <= '0;
    end else begin
      fsm       <= fsm_next;
      rnd       <= rnd_next;
      rk_idx_q  <= rk_idx_next;
      state_reg <= state_next;
      dout      <= dout_next;
    end
  end

  assign bus.in_ready  = (fsm == IDLE);
  assign bus.out_valid = (fsm == DONE);
  assign bus.busy      = (fsm != IDLE);
  assign bus.data_out  = dout;
  assign bus.rk_idx    = rk_idx_q;

endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// Scoreboard bench for aes_inv_cipher_iter: AES-128/192/256 instances, FIPS-197
// vectors plus random blocks encrypted by an independent forward-cipher model.
module tb_aes_inv_cipher_iter;

  localparam int NR [3] = '{10, 12, 14};
  localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT2 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT3 = 128'h8ea2b7ca516745bfeafc49904b496089;

  typedef struct {
    int           k;
    logic [127:0] pt;
  } sb_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  aes_inv_cipher_iter_if #(.RK_IDX_W(4)) bus10 ();
  aes_inv_cipher_iter_if #(.RK_IDX_W(4)) bus12 ();
  aes_inv_cipher_iter_if #(.RK_IDX_W(4)) bus14 ();

  aes_inv_cipher_iter #(.NUM_ROUNDS(10), .RK_IDX_W(4)) dut10 (.clk(clk), .rst(rst), .bus(bus10.slave));
  aes_inv_cipher_iter #(.NUM_ROUNDS(12), .RK_IDX_W(4)) dut12 (.clk(clk), .rst(rst), .bus(bus12.slave));
  aes_inv_cipher_iter #(.NUM_ROUNDS(14), .RK_IDX_W(4)) dut14 (.clk(clk), .rst(rst), .bus(bus14.slave));

  logic         drv_valid [3];
  logic         drv_ready [3];
  logic [127:0] drv_data  [3];
  logic [127:0] drv_exp   [3];
  logic         obs_ir    [3];
  logic         obs_ov    [3];
  logic         obs_busy  [3];
  logic [127:0] obs_dout  [3];
  int           obs_rk    [3];
  logic [127:0] rk_tab    [3][15];
  logic [7:0]   sb        [256];

  assign bus10.in_valid = drv_valid[0];  assign bus12.in_valid = drv_valid[1];  assign bus14.in_valid = drv_valid[2];
  assign bus10.out_ready = drv_ready[0]; assign bus12.out_ready = drv_ready[1]; assign bus14.out_ready = drv_ready[2];
  assign bus10.data_in = drv_data[0];    assign bus12.data_in = drv_data[1];    assign bus14.data_in = drv_data[2];
  assign bus10.rk_data = rk_tab[0][bus10.rk_idx];
  assign bus12.rk_data = rk_tab[1][bus12.rk_idx];
  assign bus14.rk_data = rk_tab[2][bus14.rk_idx];
  assign obs_ir[0] = bus10.in_ready;     assign obs_ir[1] = bus12.in_ready;     assign obs_ir[2] = bus14.in_ready;
  assign obs_ov[0] = bus10.out_valid;    assign obs_ov[1] = bus12.out_valid;    assign obs_ov[2] = bus14.out_valid;
  assign obs_busy[0] = bus10.busy;       assign obs_busy[1] = bus12.busy;       assign obs_busy[2] = bus14.busy;
  assign obs_dout[0] = bus10.data_out;   assign obs_dout[1] = bus12.data_out;   assign obs_dout[2] = bus14.data_out;
  assign obs_rk[0] = int'(bus10.rk_idx); assign obs_rk[1] = int'(bus12.rk_idx); assign obs_rk[2] = int'(bus14.rk_idx);

  int   n_checks = 0;
  int   n_fail = 0;
  int   cycle = 0;
  int   n_acc [3] = '{0, 0, 0};
  int   n_out [3] = '{0, 0, 0};
  int   acc_cyc [3] = '{0, 0, 0};
  int   last_out_cyc [3] = '{0, 0, 0};
  logic ov_prev [3] = '{1'b0, 1'b0, 1'b0};
  int   out_cyc [$];
  sb_t  exp_q [$];

  task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  // Forward-cipher model used to build ciphertexts for random plaintexts.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  task automatic buildSbox();
    logic [7:0] inv;
    for (int b = 0; b < 256; b++) begin
      inv = 8'h01;
      if (b == 0) inv = 8'h00;
      else for (int i = 0; i < 254; i++) inv = gmul(inv, 8'(b));
      sb[b] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subWord(input logic [31:0] w);
    return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
  endfunction

  task automatic expandKey(input int k, input int nk, input logic [255:0] key);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rcon = 8'h01;
    int          nr = nk + 6;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t = subWord({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
        rcon = xtime(rcon);
      end else if (nk > 6 && i % nk == 4) begin
        t = subWord(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r <= nr; r++) rk_tab[k][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] encryptBlock(input int k, input logic [127:0] pt);
    logic [127:0] s, t;
    logic [7:0]   a [4];
    s = pt ^ rk_tab[k][0];
    for (int r = 1; r <= NR[k]; r++) begin
      for (int i = 0; i < 16; i++) t[127-8*i -: 8] = sb[s[127-8*i -: 8]];
      for (int c = 0; c < 4; c++)
        for (int rw = 0; rw < 4; rw++) s[127-8*(rw+4*c) -: 8] = t[127-8*(rw+4*((c+rw)%4)) -: 8];
      if (r < NR[k]) begin
        for (int c = 0; c < 4; c++) begin
          for (int rw = 0; rw < 4; rw++) a[rw] = s[127-8*(rw+4*c) -: 8];
          for (int rw = 0; rw < 4; rw++)
            s[127-8*(rw+4*c) -: 8] = gmul(a[rw], 8'h02) ^ gmul(a[(rw+1)%4], 8'h03) ^ a[(rw+2)%4] ^ a[(rw+3)%4];
        end
      end
      s = s ^ rk_tab[k][r];
    end
    return s;
  endfunction

  // Pushes on acceptance, pops and compares on each output handshake.
  always @(negedge clk) begin
    cycle++;
    if (rst) begin
      exp_q.delete();
      for (int k = 0; k < 3; k++) ov_prev[k] = 1'b0;
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (drv_valid[k] && obs_ir[k]) begin
          exp_q.push_back('{k, drv_exp[k]});
          acc_cyc[k] = cycle;
          n_acc[k]++;
        end
        if (obs_ov[k] && !ov_prev[k])
          checkOutput($sformatf("latency_nr%0d", NR[k]), 128'(cycle - acc_cyc[k]), 128'(NR[k] + 1));
        if (obs_ov[k] && drv_ready[k]) begin
          int idx = -1;
          for (int i = 0; i < exp_q.size(); i++) if (idx < 0 && exp_q[i].k == k) idx = i;
          checkOutput($sformatf("sb_entry_nr%0d", NR[k]), 128'(idx >= 0), 128'(1));
          if (idx >= 0) begin
            checkOutput($sformatf("data_out_nr%0d", NR[k]), obs_dout[k], exp_q[idx].pt);
            exp_q.delete(idx);
          end
          n_out[k]++;
          last_out_cyc[k] = cycle;
          if (k == 0) out_cyc.push_back(cycle);
        end
        ov_prev[k] = obs_ov[k];
      end
    end
  end

  // Call at posedge+1; returns at posedge+1 after the acceptance edge.
  task automatic applyStimulus(input int k, input logic [127:0] ct, input logic [127:0] pt);
    int n = 0;
    bit acc = 1'b0;
    drv_data[k]  = ct;
    drv_exp[k]   = pt;
    drv_valid[k] = 1'b1;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = obs_ir[k];
      @(posedge clk);
      #1;
      n++;
    end
    drv_valid[k] = 1'b0;
    if (!acc) checkOutput("accept_timeout", 128'(acc), 128'(1));
  endtask

  task automatic waitOutputs(input int k, input int target);
    int n = 0;
    while (n_out[k] < target && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n_out[k] < target) checkOutput("output_timeout", 128'(n_out[k]), 128'(target));
  endtask

  task automatic checkIdle(input int k, input string tag);
    checkOutput({tag, "_in_ready"}, 128'(obs_ir[k]), 128'(1));
    checkOutput({tag, "_busy"}, 128'(obs_busy[k]), 128'(0));
    checkOutput({tag, "_out_valid"}, 128'(obs_ov[k]), 128'(0));
    checkOutput({tag, "_rk_idx"}, 128'(obs_rk[k]), 128'(NR[k]));
  endtask

  initial begin
    int           base, n;
    logic [127:0] rpt, rkey;
    for (int k = 0; k < 3; k++) begin
      drv_valid[k] = 1'b0;
      drv_ready[k] = 1'b1;
      drv_data[k]  = '0;
      drv_exp[k]   = '0;
    end
    buildSbox();
    expandKey(0, 4, {128'h000102030405060708090a0b0c0d0e0f, 128'h0});
    expandKey(1, 6, {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0});
    expandKey(2, 8, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checkIdle(k, $sformatf("reset_nr%0d", NR[k]));
      checkOutput($sformatf("reset_nr%0d_data_out", NR[k]), obs_dout[k], 128'h0);
    end

    // FIPS-197 C.1 with the full rk_idx sequence.
    base = n_out[0];
    checkOutput("rk_trace_accept", 128'(obs_rk[0]), 128'(10));
    applyStimulus(0, CT1, PT);
    for (int i = 1; i <= 10; i++) begin
      checkOutput($sformatf("rk_trace_%0d", i), 128'(obs_rk[0]), 128'(10 - i));
      @(posedge clk);
      #1;
    end
    waitOutputs(0, base + 1);
    checkOutput("rk_trace_after_done", 128'(obs_rk[0]), 128'(10));

    // FIPS-197 C.2 and C.3.
    applyStimulus(1, CT2, PT);
    waitOutputs(1, 1);
    applyStimulus(2, CT3, PT);
    waitOutputs(2, 1);

    // Back-pressure: result held in DONE while a new block waits.
    drv_ready[0] = 1'b0;
    applyStimulus(0, CT1, PT);
    n = 0;
    while (!obs_ov[0] && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    rpt = {$urandom, $urandom, $urandom, $urandom};
    drv_data[0]  = encryptBlock(0, rpt);
    drv_exp[0]   = rpt;
    drv_valid[0] = 1'b1;
    base = n_acc[0];
    for (int i = 0; i < 20; i++) begin
      checkOutput("stall_out_valid", 128'(obs_ov[0]), 128'(1));
      checkOutput("stall_data_out", obs_dout[0], PT);
      checkOutput("stall_in_ready", 128'(obs_ir[0]), 128'(0));
      @(posedge clk);
      #1;
    end
    drv_ready[0] = 1'b1;
    n = 0;
    while (n_acc[0] == base && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    drv_valid[0] = 1'b0;
    checkOutput("stall_accept_after_out", 128'(acc_cyc[0] - last_out_cyc[0]), 128'(1));
    waitOutputs(0, n_out[0] + 1);

    // Reset in the middle of a block; the block is dropped.
    applyStimulus(0, CT1, PT);
    n = 0;
    while (obs_rk[0] != 5 && n < 30) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("mid_reset_rnd", 128'(obs_rk[0]), 128'(5));
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkIdle(0, "mid_reset");
    checkOutput("mid_reset_data_out", obs_dout[0], 128'h0);
    base = n_out[0];
    applyStimulus(0, CT1, PT);
    waitOutputs(0, base + 1);

    // Back-to-back: DONE and IDLE each take a cycle, so blocks issue every NUM_ROUNDS+2 cycles.
    base = n_out[0];
    out_cyc.delete();
    for (int i = 0; i < 3; i++) applyStimulus(0, CT1, PT);
    waitOutputs(0, base + 3);
    checkOutput("b2b_count", 128'(out_cyc.size()), 128'(3));
    if (out_cyc.size() == 3) begin
      checkOutput("b2b_spacing_1", 128'(out_cyc[1] - out_cyc[0]), 128'(12));
      checkOutput("b2b_spacing_2", 128'(out_cyc[2] - out_cyc[1]), 128'(12));
    end

    // Random keys and plaintexts; keys only change while every instance is idle.
    for (int j = 0; j < 3; j++) begin
      for (int k = 0; k < 3; k++) begin
        rkey = {$urandom, $urandom, $urandom, $urandom};
        expandKey(k, 4 + 2*k, {rkey, rkey ^ {$urandom, $urandom, $urandom, $urandom}});
        rpt = {$urandom, $urandom, $urandom, $urandom};
        base = n_out[k];
        applyStimulus(k, encryptBlock(k, rpt), rpt);
        waitOutputs(k, base + 1);
      end
    end

    repeat (2) @(posedge clk);
    #1;
    checkOutput("scoreboard_empty", 128'(exp_q.size()), 128'(0));
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
